// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle ripple adder/subtractor, CHUNK bits per clock.
// Valid/ready on both sides; result and flags held in DONE until taken.
module seq_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             v,
   output logic             z,
   output logic             n,
   output logic             p
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opa_nxt;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] opb_nxt;
   logic [WIDTH-1:0] s_nxt;
   logic             carry;
   logic             carry_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             cout_nxt;
   logic             v_nxt;
   logic             z_nxt;
   logic             n_nxt;
   logic             p_nxt;
   logic [CHUNK:0]   csum;
   logic             last;
   int               base;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last      = (cnt == CW'(NCH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         s     <= '0;
         cout  <= 1'b0;
         v     <= 1'b0;
         z     <= 1'b0;
         n     <= 1'b0;
         p     <= 1'b0;
      end else begin
         state <= state_nxt;
         opa   <= opa_nxt;
         opb   <= opb_nxt;
         carry <= carry_nxt;
         cnt   <= cnt_nxt;
         s     <= s_nxt;
         cout  <= cout_nxt;
         v     <= v_nxt;
         z     <= z_nxt;
         n     <= n_nxt;
         p     <= p_nxt;
      end
   end

   // One CHUNK+1 bit slice of the ripple chain per clock
   always_comb begin
      base = int'(cnt) * CHUNK;
      csum = {1'b0, opa[base +: CHUNK]}
           + {1'b0, opb[base +: CHUNK]}
           + {{CHUNK{1'b0}}, carry};
   end

   always_comb begin
      state_nxt = state;
      opa_nxt   = opa;
      opb_nxt   = opb;
      carry_nxt = carry;
      cnt_nxt   = cnt;
      s_nxt     = s;
      cout_nxt  = cout;
      v_nxt     = v;
      z_nxt     = z;
      n_nxt     = n;
      p_nxt     = p;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               opa_nxt   = a;
               opb_nxt   = b ^ {WIDTH{sub}};
               carry_nxt = sub;
               cnt_nxt   = '0;
               state_nxt = CALC;
            end
         end
         CALC: begin
            s_nxt[base +: CHUNK] = csum[CHUNK-1:0];
            carry_nxt = csum[CHUNK];
            cnt_nxt   = cnt + 1'b1;
            if (last) begin
               cnt_nxt   = '0;
               cout_nxt  = csum[CHUNK];
               v_nxt     = (opa[WIDTH-1] == opb[WIDTH-1])
                        && (s_nxt[WIDTH-1] != opa[WIDTH-1]);
               z_nxt     = ~|s_nxt;
               n_nxt     = s_nxt[WIDTH-1];
               p_nxt     = ^s_nxt;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed and random checks of seq_addsub against an
// arithmetic reference, for 8/4 plus 8/1, 16/8 and 32/32 configurations.
module tb_seq_addsub;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_sw_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       sub;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] s;
   logic       cout;
   logic       v;
   logic       z;
   logic       n;
   logic       p;

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   seq_addsub #(.WIDTH(8), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .v(v), .z(z), .n(n), .p(p)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
   endtask

   // Reference: plain integer arithmetic; flags = {cout,v,z,n,p}
   function automatic void ref_op(input int w, input logic [63:0] ua,
                                  input logic [63:0] ub, input logic sb,
                                  output logic [63:0] rs,
                                  output logic [4:0] rf);
      logic [63:0] m;
      longint      half;
      longint      sa;
      longint      sbv;
      longint      r;
      logic        c;
      logic        ov;
      m    = (64'd1 << w) - 64'd1;
      ua   = ua & m;
      ub   = ub & m;
      half = longint'(64'd1 << (w - 1));
      sa   = longint'(ua);
      sbv  = longint'(ub);
      if (sa >= half) sa = sa - 2 * half;
      if (sbv >= half) sbv = sbv - 2 * half;
      if (sb) begin
         rs = (ua - ub) & m;
         c  = (ua >= ub);
         r  = sa - sbv;
      end else begin
         rs = (ua + ub) & m;
         c  = ((ua + ub) > m);
         r  = sa + sbv;
      end
      ov = (r >= half) || (r < -half);
      rf = {c, ov, (rs == 64'd0), rs[w-1], ^rs};
   endfunction

   task automatic chk_rst(input string tag);
      chk({tag, "_s"}, 64'(s), 64'd0);
      chk({tag, "_flags"}, 64'({cout, v, z, n, p}), 64'd0);
      chk({tag, "_ovalid"}, 64'(out_valid), 64'd0);
      chk({tag, "_iready"}, 64'(in_ready), 64'd1);
   endtask

   // One op on the 8/4 instance; inputs scrambled after acceptance
   task automatic op8(input string tag, input logic [7:0] ta,
                      input logic [7:0] tb_, input logic ts,
                      input int hold, input logic [7:0] es,
                      input logic [4:0] ef);
      int lat;
      a        = ta;
      b        = tb_;
      sub      = ts;
      in_valid = 1'b1;
      @(posedge clk); #1;
      a   = 8'($urandom);
      b   = 8'($urandom);
      sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd2);
      chk({tag, "_s"}, 64'(s), 64'(es));
      chk({tag, "_flags"}, 64'({cout, v, z, n, p}), 64'(ef));
      for (int i = 0; i < hold; i++) begin
         a        = 8'($urandom);
         b        = 8'($urandom);
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         chk({tag, "_bp_s"}, 64'(s), 64'(es));
         chk({tag, "_bp_flags"}, 64'({cout, v, z, n, p}), 64'(ef));
         chk({tag, "_bp_rdy"}, 64'({in_ready, out_valid}), 64'b01);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
   endtask

   localparam int SW[3] = '{8, 16, 32};
   localparam int SC[3] = '{1, 8, 32};

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = SW[g];
      localparam int C = SC[g];
      localparam int N = W / C;
      logic         iv;
      logic         ir;
      logic [W-1:0] aa;
      logic [W-1:0] bb;
      logic         sb;
      logic         ov;
      logic         ordy;
      logic [W-1:0] ss;
      logic         co;
      logic         vv;
      logic         zz;
      logic         nn;
      logic         pp;
      logic         done;

      seq_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
         .clk(clk), .rst_n(rst_sw_n),
         .in_valid(iv), .in_ready(ir),
         .a(aa), .b(bb), .sub(sb),
         .out_valid(ov), .out_ready(ordy),
         .s(ss), .cout(co), .v(vv), .z(zz), .n(nn), .p(pp)
      );

      initial begin
         logic [63:0] m;
         logic [63:0] ra;
         logic [63:0] rb;
         logic [63:0] es;
         logic [4:0]  ef;
         logic        rs;
         int          lat;
         string       tag;
         done = 1'b0;
         iv   = 1'b0;
         ordy = 1'b0;
         aa   = '0;
         bb   = '0;
         sb   = 1'b0;
         m    = (64'd1 << W) - 64'd1;
         tag  = $sformatf("sw%0d_%0d", W, C);
         wait (rst_sw_n === 1'b1);
         @(posedge clk); #1;
         for (int i = 0; i < 1000; i++) begin
            ra = {32'($urandom), 32'($urandom)} & m;
            rb = {32'($urandom), 32'($urandom)} & m;
            rs = 1'($urandom);
            if (i % 7 == 0) ra = m;
            if (i % 11 == 0) rb = (m >> 1) + 64'd1;
            ref_op(W, ra, rb, rs, es, ef);
            aa = W'(ra);
            bb = W'(rb);
            sb = rs;
            iv = 1'b1;
            @(posedge clk); #1;
            aa  = W'({32'($urandom), 32'($urandom)});
            bb  = W'({32'($urandom), 32'($urandom)});
            sb  = 1'($urandom);
            lat = 0;
            while (!ov && lat < 100) begin
               @(posedge clk); #1;
               lat++;
            end
            chk({tag, "_lat"}, 64'(lat), 64'(N));
            chk({tag, "_s"}, 64'(ss), es);
            chk({tag, "_flags"}, 64'({co, vv, zz, nn, pp}), 64'(ef));
            iv   = 1'b0;
            ordy = 1'b1;
            @(posedge clk); #1;
            ordy = 1'b0;
            chk({tag, "_idle"}, 64'({ir, ov}), 64'b10);
         end
         done = 1'b1;
      end
   end

   initial begin
      logic [63:0] es;
      logic [4:0]  ef;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic        rs;
      int          t;
      rst_n     = 1'b0;
      rst_sw_n  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_rst("reset");
      rst_n    = 1'b1;
      rst_sw_n = 1'b1;
      @(posedge clk); #1;

      op8("add7f01", 8'h7f, 8'h01, 1'b0, 0, 8'h80, 5'b01011);
      op8("addff01", 8'hff, 8'h01, 1'b0, 0, 8'h00, 5'b10100);
      op8("sub0507", 8'h05, 8'h07, 1'b1, 0, 8'hfe, 5'b00011);
      op8("sub8001", 8'h80, 8'h01, 1'b1, 0, 8'h7f, 5'b11001);
      op8("bp", 8'hc3, 8'h42, 1'b1, 5, 8'h81, 5'b10010);

      a        = 8'h33;
      b        = 8'h44;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_rst("midrst");
      @(posedge clk); #1;
      chk("midrst_hold", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      op8("add1020", 8'h10, 8'h20, 1'b0, 0, 8'h30, 5'b00000);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         ref_op(8, 64'(ra), 64'(rb), rs, es, ef);
         op8("rnd8_4", ra, rb, rs, $urandom_range(0, 2), es[7:0], ef);
      end

      t = 0;
      while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)
             && t < 40000) begin
         @(posedge clk);
         t++;
      end
      chk("sweep_done",
          64'({g_sw[0].done, g_sw[1].done, g_sw[2].done}), 64'b111);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
